labfinal_soc_cmd_out_pio: RTL and testbench

Avalon-MM memory-mapped output port for the labfinal SoC: the Nios II writes 10-bit command words that the block presents to fabric logic over a valid/ack handshake. It is the CPU-to-hardware counterpart of the score input PIO, which carries hardware-to-CPU data. A two-entry buffer (presented word plus one pending word) decouples software writes from fabric consumption. Status reporting covers busy, pending and overrun.

---
 rtl/labfinal_pio_pkg.sv | 12 +
 rtl/labfinal_soc_cmd_out_pio_if.sv | 13 +
 rtl/labfinal_out_buf2.sv | 53 +++++
 rtl/labfinal_soc_cmd_out_pio.sv | 60 ++++++
 tb/tb_labfinal_soc_cmd_out_pio.sv | 211 +++++++++++++++++++++
 5 files changed

// File: rtl/labfinal_pio_pkg.sv
// labfinal_pio_pkg: register map, status/control bit indices and buffer states for the PIO blocks
package labfinal_pio_pkg;
  localparam logic [1:0] ADDR_DATA = 2'd0;
  localparam logic [1:0] ADDR_STATUS = 2'd1;
  localparam logic [1:0] ADDR_CONTROL = 2'd2;
  localparam int ST_BUSY = 0;
  localparam int ST_PEND = 1;
  localparam int ST_OVR = 2;
  localparam int CTL_IRQ_EMPTY = 0;
  localparam int CTL_IRQ_OVR = 1;
  typedef enum logic [1:0] {EMPTY, ONE, FULL} buf_state_t;
endpackage

// File: rtl/labfinal_soc_cmd_out_pio_if.sv
// labfinal_soc_cmd_out_pio_if: Avalon-MM slave bus plus the fabric-side valid/ack command port
interface labfinal_soc_cmd_out_pio_if #(parameter int DATA_W = 10);
  logic [1:0] address;
  logic chipselect;
  logic write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;
  logic [DATA_W-1:0] out_port;
  logic out_valid;
  logic out_ack;
  modport slave(input address, chipselect, write_n, writedata, out_ack, output readdata, out_port, out_valid);
  modport master(output address, chipselect, write_n, writedata, out_ack, input readdata, out_port, out_valid);
endinterface

// File: rtl/labfinal_out_buf2.sv
// labfinal_out_buf2: two-entry valid/ack buffer; ack is applied before push within a cycle
module labfinal_out_buf2
  import labfinal_pio_pkg::*;
#(parameter int DATA_W = 10) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              push,
  input  logic [DATA_W-1:0] push_data,
  input  logic              ack,
  output logic [DATA_W-1:0] data,
  output logic              valid,
  output logic              pend_valid,
  output logic              drop
);
  buf_state_t state;
  logic [DATA_W-1:0] pend_data;
  assign drop = push & pend_valid & ~ack;
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= EMPTY;
      data <= '0;
      valid <= 1'b0;
      pend_data <= '0;
      pend_valid <= 1'b0;
    end else begin
      case (state)
        EMPTY: if (push) begin
          data <= push_data;
          valid <= 1'b1;
          state <= ONE;
        end
        ONE: if (ack && push) data <= push_data;
        else if (ack) begin
          valid <= 1'b0;
          state <= EMPTY;
        end else if (push) begin
          pend_data <= push_data;
          pend_valid <= 1'b1;
          state <= FULL;
        end
        FULL: if (ack) begin
          data <= pend_data;
          if (push) pend_data <= push_data;
          else begin
            pend_valid <= 1'b0;
            state <= ONE;
          end
        end
        default: state <= EMPTY;
      endcase
    end
  end
endmodule

// File: rtl/labfinal_soc_cmd_out_pio.sv
// labfinal_soc_cmd_out_pio: Avalon-MM command output PIO; define CMD_OUT_IRQ_EN for the irq port
module labfinal_soc_cmd_out_pio
  import labfinal_pio_pkg::*;
#(parameter int DATA_W = 10) (
  input  logic clk,
  input  logic reset_n,
  labfinal_soc_cmd_out_pio_if.slave bus
`ifdef CMD_OUT_IRQ_EN
  ,
  output logic irq
`endif
);
  logic wr, push, ovr_clr, ctl_wr, drop, pend_valid, overrun;
  logic [1:0] control;
  logic [31:0] status, rd_next;
  logic unused_wd;
  assign wr = bus.chipselect & ~bus.write_n;
  assign push = wr & (bus.address == ADDR_DATA);
  assign ovr_clr = wr & (bus.address == ADDR_STATUS) & bus.writedata[ST_OVR];
  assign ctl_wr = wr & (bus.address == ADDR_CONTROL);
  assign unused_wd = ^bus.writedata;
  labfinal_out_buf2 #(.DATA_W(DATA_W)) u_buf (
    .clk(clk),
    .reset_n(reset_n),
    .push(push),
    .push_data(bus.writedata[DATA_W-1:0]),
    .ack(bus.out_ack),
    .data(bus.out_port),
    .valid(bus.out_valid),
    .pend_valid(pend_valid),
    .drop(drop)
  );
  always_comb begin
    status = '0;
    status[ST_BUSY] = bus.out_valid;
    status[ST_PEND] = pend_valid;
    status[ST_OVR] = overrun;
    rd_next = bus.address == ADDR_DATA ? {{(32-DATA_W){1'b0}}, bus.out_port} :
              bus.address == ADDR_STATUS ? status :
              bus.address == ADDR_CONTROL ? {30'b0, control} : '0;
  end
  // a drop in the same cycle as a clear wins so no overrun is ever lost
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      overrun <= 1'b0;
      control <= '0;
      bus.readdata <= '0;
    end else begin
      overrun <= drop ? 1'b1 : ovr_clr ? 1'b0 : overrun;
      control <= ctl_wr ? bus.writedata[1:0] : control;
      bus.readdata <= rd_next;
    end
  end
`ifdef CMD_OUT_IRQ_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) irq <= 1'b0;
    else irq <= (control[CTL_IRQ_EMPTY] & ~bus.out_valid) | (control[CTL_IRQ_OVR] & overrun);
  end
`endif
endmodule

// File: tb/tb_labfinal_soc_cmd_out_pio.sv
// tb_labfinal_soc_cmd_out_pio: scoreboard bench for reads, consumed words and valid/irq state
module tb_labfinal_soc_cmd_out_pio;
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic irq_w;
  logic chk_now = 1'b0;
  logic done = 1'b0;
  int checks = 0;
  int errors = 0;
  logic [31:0] rd_q[$];
  logic [9:0] cons_q[$];
  logic [1:0] st_q[$];
  labfinal_soc_cmd_out_pio_if #(.DATA_W(10)) bus ();
`ifdef CMD_OUT_IRQ_EN
  labfinal_soc_cmd_out_pio dut (.clk(clk), .reset_n(reset_n), .bus(bus), .irq(irq_w));
`else
  labfinal_soc_cmd_out_pio dut (.clk(clk), .reset_n(reset_n), .bus(bus));
  assign irq_w = 1'b0;
`endif
  always #5 clk = ~clk;
  task automatic step(input logic [1:0] a, input logic c, input logic w, input logic [31:0] d, input logic k);
    bus.address = a;
    bus.chipselect = c;
    bus.write_n = w;
    bus.writedata = d;
    bus.out_ack = k;
    @(posedge clk);
    #1;
    chk_now = 1'b0;
  endtask
  task automatic wr(input logic [1:0] a, input logic [31:0] d, input logic k);
    step(a, 1'b1, 1'b0, d, k);
  endtask
  task automatic rd(input logic [1:0] a, input logic [31:0] e);
    rd_q.push_back(e);
    step(a, 1'b1, 1'b1, 32'h0, 1'b0);
  endtask
  task automatic idle(input logic k);
    step(2'd0, 1'b0, 1'b1, 32'h0, k);
  endtask
  task automatic ack_word(input logic [9:0] w);
    cons_q.push_back(w);
    idle(1'b1);
  endtask
  task automatic expect_st(input logic v, input logic i);
    st_q.push_back({v, i});
    chk_now = 1'b1;
  endtask
  // monitor: every comparison happens here, at the falling edge
  initial begin
    logic rd_live;
    logic [31:0] e;
    logic [9:0] w;
    logic [1:0] s;
    rd_live = 1'b0;
    forever begin
      @(negedge clk);
      if (rd_live) begin
        checks++;
        if (rd_q.size() == 0) begin
          errors++;
          $display("FAIL readdata: got %h with no read expected", bus.readdata);
        end else begin
          e = rd_q.pop_front();
          if (bus.readdata !== e) begin
            errors++;
            $display("FAIL readdata: got %h, expected %h", bus.readdata, e);
          end
        end
      end
      rd_live = bus.chipselect & bus.write_n;
      if (bus.out_valid && bus.out_ack) begin
        checks++;
        if (cons_q.size() == 0) begin
          errors++;
          $display("FAIL consume: word %h consumed, none expected", bus.out_port);
        end else begin
          w = cons_q.pop_front();
          if (bus.out_port !== w) begin
            errors++;
            $display("FAIL consume: got %h, expected %h", bus.out_port, w);
          end
        end
      end
      if (chk_now && st_q.size() != 0) begin
        s = st_q.pop_front();
        checks++;
        if ({bus.out_valid, irq_w} !== s) begin
          errors++;
          $display("FAIL state: out_valid/irq got %b, expected %b", {bus.out_valid, irq_w}, s);
        end
      end
      if (done) begin
        checks++;
        if (rd_q.size() + cons_q.size() + st_q.size() != 0) begin
          errors++;
          $display("FAIL leftover: %0d expectations never observed", rd_q.size() + cons_q.size() + st_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
      end
    end
  end
  initial begin
    bus.address = 2'd0;
    bus.chipselect = 1'b0;
    bus.write_n = 1'b1;
    bus.writedata = 32'h0;
    bus.out_ack = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    reset_n = 1'b1;
    expect_st(1'b0, 1'b0);
    rd(2'd0, 32'h0);
    rd(2'd1, 32'h0);
    rd(2'd2, 32'h0);
    rd(2'd3, 32'h0);
    wr(2'd0, 32'hFFFF_F155, 1'b0);
    expect_st(1'b1, 1'b0);
    rd(2'd1, 32'h1);
    rd(2'd0, 32'h155);
    ack_word(10'h155);
    expect_st(1'b0, 1'b0);
    rd(2'd1, 32'h0);
    wr(2'd0, 32'h1, 1'b0);
    wr(2'd0, 32'h2, 1'b0);
    wr(2'd0, 32'h3, 1'b0);
    rd(2'd0, 32'h1);
    rd(2'd1, 32'h7);
    ack_word(10'h001);
    rd(2'd0, 32'h2);
    rd(2'd1, 32'h5);
    ack_word(10'h002);
    rd(2'd1, 32'h4);
    wr(2'd1, 32'h4, 1'b0);
    rd(2'd1, 32'h0);
    wr(2'd0, 32'h10, 1'b0);
    wr(2'd0, 32'h20, 1'b0);
    cons_q.push_back(10'h010);
    wr(2'd0, 32'h3FF, 1'b1);
    rd(2'd0, 32'h20);
    rd(2'd1, 32'h3);
    cons_q.push_back(10'h020);
    wr(2'd0, 32'h31, 1'b1);
    cons_q.push_back(10'h3FF);
    wr(2'd0, 32'h32, 1'b1);
    cons_q.push_back(10'h031);
    wr(2'd0, 32'h33, 1'b1);
    cons_q.push_back(10'h032);
    wr(2'd0, 32'h34, 1'b1);
    ack_word(10'h033);
    ack_word(10'h034);
    rd(2'd1, 32'h0);
    wr(2'd0, 32'h40, 1'b0);
    wr(2'd0, 32'h41, 1'b0);
    wr(2'd0, 32'h42, 1'b0);
    rd(2'd1, 32'h7);
    rd(2'd1, 32'h7);
    wr(2'd1, 32'hFFFF_FFFB, 1'b0);
    rd(2'd1, 32'h7);
    wr(2'd1, 32'h4, 1'b0);
    rd(2'd1, 32'h3);
    ack_word(10'h040);
    ack_word(10'h041);
    rd(2'd1, 32'h0);
    wr(2'd2, 32'hFFFF_FFFF, 1'b0);
    rd(2'd2, 32'h3);
    wr(2'd2, 32'h0, 1'b0);
    rd(2'd2, 32'h0);
    wr(2'd3, 32'hFFFF, 1'b0);
    rd(2'd3, 32'h0);
    rd(2'd1, 32'h0);
    rd(2'd2, 32'h0);
`ifdef CMD_OUT_IRQ_EN
    wr(2'd2, 32'h1, 1'b0);
    expect_st(1'b0, 1'b0);
    idle(1'b0);
    expect_st(1'b0, 1'b1);
    wr(2'd0, 32'h50, 1'b0);
    expect_st(1'b1, 1'b1);
    idle(1'b0);
    expect_st(1'b1, 1'b0);
    wr(2'd2, 32'h2, 1'b0);
    wr(2'd0, 32'h51, 1'b0);
    wr(2'd0, 32'h52, 1'b0);
    idle(1'b0);
    expect_st(1'b1, 1'b1);
    wr(2'd1, 32'h4, 1'b0);
    idle(1'b0);
    expect_st(1'b1, 1'b0);
    ack_word(10'h050);
    ack_word(10'h051);
    wr(2'd2, 32'h0, 1'b0);
`endif
    wr(2'd0, 32'h60, 1'b0);
    wr(2'd0, 32'h61, 1'b0);
    reset_n = 1'b0;
    #1;
    expect_st(1'b0, 1'b0);
    idle(1'b0);
    reset_n = 1'b1;
    rd(2'd1, 32'h0);
    rd(2'd0, 32'h0);
    idle(1'b0);
    idle(1'b0);
    done = 1'b1;
    repeat (5) @(posedge clk);
    $display("FAIL timeout: monitor did not finish");
    $fatal(1);
  end
endmodule
